fsbm_search_ctrl: RTL
=====================

FSBM_SEARCH_CTRL -- requirements
Module: fsbm_search_ctrl

Interface
REQ-001 Parameter SAD_W, default 12, SHALL set the bit width of each SAD value and of the MAD field.
REQ-002 Parameter NCAND, default 16, SHALL set the number of candidate positions per search; the search window is 4x4.
REQ-003 Parameter MAX_OUT, default 4, SHALL set the maximum number of requests issued but not yet answered.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL be a one-cycle request to begin a search; it is sampled only in IDLE.
REQ-007 abort  input  1  SHALL be a synchronous cancel of the search in progress.
REQ-008 req_valid  output  1  SHALL flag a candidate SAD request to the SAD datapath.
REQ-009 req_ready  input  1  SHALL indicate that the datapath accepts the request this cycle.
REQ-010 req_idx  output  4  SHALL be the candidate index of the current request.
REQ-011 sad_valid  input  1  SHALL qualify sad; SAD results return in request order.
REQ-012 sad  input  SAD_W  SHALL be the SAD of the oldest outstanding candidate.
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-014 done  output  1  SHALL be a one-cycle pulse marking that the result is valid.
REQ-015 out  output  SAD_W+8  SHALL carry the result as {mad, mv}.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE when the NCAND-th SAD is received.
- DONE->IDLE unconditionally after 1 cycle.
- Any state->IDLE on abort; abort has priority over all other events.
REQ-017 In RUN, req_valid SHALL be high iff issued<NCAND and outstanding<MAX_OUT.
REQ-018 A request SHALL transfer on req_valid&req_ready; req_idx SHALL increment 0..NCAND-1 and SHALL hold stable while req_valid=1 and req_ready=0.
REQ-019 The outstanding counter SHALL +1 on transfer only, -1 on sad_valid only, and stay unchanged when both occur in the same cycle.
REQ-020 The first SAD of a search SHALL load min_sad=sad and min_idx=0.
REQ-021 Each later SAD SHALL replace min_sad/min_idx only if sad < min_sad (strict), so ties keep the lowest index.
REQ-022 mv SHALL equal {2'b00, min_idx[3:2], 2'b00, min_idx[1:0]}; examples: idx 5 -> 8'h11, idx 15 -> 8'h33.
REQ-023 out SHALL update in the cycle done=1 and hold until the next done or reset; done and busy SHALL both be 1 in DONE.
REQ-024 Latency: start at cycle T SHALL give req_valid at T+1; done SHALL come 1 cycle after the last sad_valid.
REQ-025 start outside IDLE SHALL be ignored; sad_valid in IDLE or DONE, or with outstanding=0, SHALL be ignored.
REQ-026 abort SHALL clear all counters and min state; it SHALL NOT change out and SHALL NOT pulse done.
REQ-027 After an abort, late sad_valid beats SHALL be ignored while in IDLE.
REQ-028 The SAD compare SHALL be unsigned at full SAD_W width with no saturation.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, out=0, done=0, busy=0, req_valid=0, req_idx=0, counters=0, min state=0.
REQ-030 Reset asserted mid-search SHALL discard that search without a done pulse; operation SHALL resume on the first clock edge after release.

Verification
REQ-031 req_ready=1, 2-cycle SAD latency, sad[i]=100+i -> single done pulse, out={12'd100, 8'h00}.
REQ-032 All sad=50 except sad[6]=20 and sad[9]=20 -> out={12'd20, 8'h12}, confirming lowest-index tie-break.
REQ-033 req_ready=1, SAD latency 8 -> outstanding never exceeds 4 and req_valid drops while outstanding=4; result correct.
REQ-034 req_ready toggles every cycle -> req_idx holds when req_ready=0, no index is skipped or repeated, exactly 16 transfers occur.
REQ-035 abort after 7 SADs -> busy=0 next cycle, out keeps its previous value, no done; a following start gives a correct full search.
REQ-036 rst_n pulsed low mid-RUN -> all outputs read 0 immediately (asynchronous); start after release completes normally.

Source files
------------

// File: rtl/fsbm_search_ctrl.sv
// Full-search block-matching controller: issues 16 candidate SAD requests
// over a 4x4 window, tracks the minimum SAD and reports {mad, mv}.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin a search (IDLE only) / cancel the search
//   req_valid/req_ready candidate request handshake, req_idx = candidate index
//   sad_valid, sad      in-order SAD results from the datapath
//   busy, done, out     status, one-cycle done pulse, result {mad, mv}
module fsbm_search_ctrl #(
    parameter int SAD_W   = 12,
    parameter int NCAND   = 16,
    parameter int MAX_OUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [3:0]         req_idx,
    input  logic               sad_valid,
    input  logic [SAD_W-1:0]   sad,
    output logic               busy,
    output logic               done,
    output logic [SAD_W+7:0]   out
);

    localparam int CNT_W = $clog2(NCAND + 1);
    localparam int OST_W = $clog2(MAX_OUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] NCAND_C = CNT_W'(NCAND);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(NCAND - 1);
    localparam logic [OST_W-1:0] MAXO_C  = OST_W'(MAX_OUT);

    logic [1:0]       state;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] rcvd;
    logic [OST_W-1:0] outst;
    logic [SAD_W-1:0] min_sad;
    logic [3:0]       min_idx;
    logic [SAD_W-1:0] nxt_sad;
    logic [3:0]       nxt_idx;
    logic             xfer;
    logic             sad_take;
    logic             take_new;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign req_valid = (state == RUN) && (issued < NCAND_C) && (outst < MAXO_C);
    assign req_idx   = 4'(issued);
    assign xfer      = req_valid & req_ready;

    // Beats with nothing outstanding, or outside RUN, are stale and dropped.
    assign sad_take  = (state == RUN) && sad_valid && (outst != '0);

    // First result always loads; later ones only on a strictly smaller SAD,
    // so ties keep the lowest candidate index.
    assign take_new  = (rcvd == '0) || (sad < min_sad);
    assign nxt_sad   = take_new ? sad : min_sad;
    assign nxt_idx   = take_new ? 4'(rcvd) : min_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            issued  <= '0;
            rcvd    <= '0;
            outst   <= '0;
            min_sad <= '0;
            min_idx <= '0;
            out     <= '0;
        end else if (abort) begin
            state   <= IDLE;
            issued  <= '0;
            rcvd    <= '0;
            outst   <= '0;
            min_sad <= '0;
            min_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (xfer) issued <= issued + CNT_W'(1);
                    case ({xfer, sad_take})
                        2'b10:   outst <= outst + OST_W'(1);
                        2'b01:   outst <= outst - OST_W'(1);
                        default: outst <= outst;
                    endcase
                    if (sad_take) begin
                        min_sad <= nxt_sad;
                        min_idx <= nxt_idx;
                        rcvd    <= rcvd + CNT_W'(1);
                        if (rcvd == LAST_C) begin
                            state <= DONE;
                            // mv packs the 4x4 window row/column as two nibbles.
                            out   <= {nxt_sad, 2'b00, nxt_idx[3:2],
                                      2'b00, nxt_idx[1:0]};
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    issued  <= '0;
                    rcvd    <= '0;
                    outst   <= '0;
                    min_sad <= '0;
                    min_idx <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
